// File: rtl/aes_block_pkg.sv
// Shared definitions for the AES state-block path: block geometry, state type,
// the receive FSM encoding and the byte placement rule.
package aes_block_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned STATE_W     = BLOCK_BYTES * BYTE_W;
    localparam int unsigned IDX_W       = 4;

    // Element [BLOCK_BYTES-1] is the MSB byte, i.e. state index 0.
    typedef logic [BLOCK_BYTES-1:0][BYTE_W-1:0] state_t;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } rx_state_t;

    // Stream position n (row-major) to state index k (column-major when transposing).
    function automatic logic [IDX_W-1:0] place_idx(input logic [IDX_W-1:0] n,
                                                  input logic             transpose);
        return transpose ? {n[1:0], n[3:2]} : n;
    endfunction

endpackage

// File: rtl/block_slot.sv
// Output slot: holds one completed block and its valid flag for the consumer handshake.
module block_slot
    import aes_block_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [STATE_W-1:0] load_data,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_buf,
    output logic               out_valid
);

    // A load always wins over a completing handshake so back-to-back blocks keep valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_buf   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_buf   <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/block_rx_transpose.sv
// Byte-serial receiver assembling a 128-bit AES state with the transpose fused in.
// Optional flush input enabled by defining BLOCK_RX_FLUSH_EN.
module block_rx_transpose
    import aes_block_pkg::*;
#(
    parameter int unsigned TRANSPOSE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef BLOCK_RX_FLUSH_EN
    ,
    input  logic               flush
`endif
);

    rx_state_t        state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    state_t           fill_buf, fill_nxt, merged, load_data;
    logic [IDX_W-1:0] place_k, slot;
    logic             flush_en, accept, slot_free, load;

`ifdef BLOCK_RX_FLUSH_EN
    assign flush_en = flush;
`else
    assign flush_en = 1'b0;
`endif

    // in_ready decodes registered state only; no path from out_ready.
    assign in_ready  = (state == ST_FILL);
    assign accept    = in_valid && in_ready && !flush_en;
    assign slot_free = !out_valid || out_ready;
    assign place_k   = place_idx(cnt, TRANSPOSE != 0);
    assign slot      = 4'(BLOCK_BYTES - 1) - place_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            cnt      <= '0;
            fill_buf <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            fill_buf <= fill_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        fill_nxt      = fill_buf;
        load          = 1'b0;
        load_data     = fill_buf;
        merged        = fill_buf;
        merged[slot]  = in_data;

        case (state)
            ST_FILL: begin
                if (flush_en) begin
                    cnt_nxt  = '0;
                    fill_nxt = '0;
                end else if (accept) begin
                    fill_nxt = merged;
                    cnt_nxt  = cnt + 4'd1;
                    // Final byte: hand the merged block straight to the slot if it is free.
                    if (cnt == 4'(BLOCK_BYTES - 1)) begin
                        if (slot_free) begin
                            load      = 1'b1;
                            load_data = merged;
                        end else begin
                            state_nxt = ST_PENDING;
                        end
                    end
                end
            end
            ST_PENDING: begin
                if (flush_en) begin
                    state_nxt = ST_FILL;
                    cnt_nxt   = '0;
                    fill_nxt  = '0;
                end else if (out_ready) begin
                    load      = 1'b1;
                    load_data = fill_buf;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    block_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (STATE_W'(load_data)),
        .out_ready (out_ready),
        .out_buf   (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_block_rx_transpose.sv
// Self-checking bench for block_rx_transpose: TRANSPOSE=1 and TRANSPOSE=0 instances
// share one stream and are compared every cycle with a block-level reference model.
module tb_block_rx_transpose;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         out_ready;
    logic         flush;
    logic         in_ready1, in_ready0;
    logic [127:0] out_data1, out_data0;
    logic         out_valid1, out_valid0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]   m_bytes [16];
    int           m_cnt;
    bit           m_pend;
    bit           m_outv;
    logic [127:0] m_out1, m_out0, m_fill1, m_fill0;

    always #5 clk = ~clk;

    block_rx_transpose #(.TRANSPOSE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready)
`ifdef BLOCK_RX_FLUSH_EN
        , .flush(flush)
`endif
    );

    block_rx_transpose #(.TRANSPOSE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready)
`ifdef BLOCK_RX_FLUSH_EN
        , .flush(flush)
`endif
    );

    function automatic logic [127:0] build(input bit tr);
        logic [127:0] blk;
        int k;
        blk = '0;
        for (int n = 0; n < 16; n++) begin
            k = tr ? (4 * (n % 4) + n / 4) : n;
            blk[127 - 8 * k -: 8] = m_bytes[n];
        end
        return blk;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_pend = 0;
        m_outv = 0;
        m_out1 = '0;
        m_out0 = '0;
        m_fill1 = '0;
        m_fill0 = '0;
        for (int n = 0; n < 16; n++) m_bytes[n] = 8'h00;
    endtask

    // Advance the model by one clock edge given the inputs presented before it.
    task automatic model_step(input logic [7:0] d, input bit iv, input bit ordy, input bit fl);
        bit hs, ld;
        hs = m_outv && ordy;
        ld = 0;
        if (fl) begin
            m_cnt  = 0;
            m_pend = 0;
        end else if (m_pend) begin
            if (ordy) begin
                m_out1 = m_fill1;
                m_out0 = m_fill0;
                m_pend = 0;
                ld     = 1;
            end
        end else if (iv) begin
            m_bytes[m_cnt] = d;
            if (m_cnt == 15) begin
                m_cnt   = 0;
                m_fill1 = build(1);
                m_fill0 = build(0);
                if (!m_outv || ordy) begin
                    m_out1 = m_fill1;
                    m_out0 = m_fill0;
                    ld     = 1;
                end else begin
                    m_pend = 1;
                end
            end else begin
                m_cnt++;
            end
        end
        if (ld) m_outv = 1;
        else if (hs) m_outv = 0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready_t1", 128'(in_ready1), 128'(!m_pend));
        chk("in_ready_t0", 128'(in_ready0), 128'(!m_pend));
        chk("out_valid_t1", 128'(out_valid1), 128'(m_outv));
        chk("out_valid_t0", 128'(out_valid0), 128'(m_outv));
        chk("out_data_t1", out_data1, m_out1);
        chk("out_data_t0", out_data0, m_out0);
    endtask

    // One clock: drive inputs, step the model, sample #1 after the edge.
    task automatic cycle(input logic [7:0] d, input bit iv, input bit ordy, input bit fl);
        in_data   = d;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        model_step(d, iv, ordy, fl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_bytes(input logic [7:0] base, input int num, input bit ordy);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < num && guard < 200) begin
            acc = !m_pend;
            cycle(8'(base + i), 1'b1, ordy, 1'b0);
            if (acc) i++;
            guard++;
        end
        chk("send_bytes_timeout", 128'(i), 128'(num));
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_in_ready", 128'(in_ready1), 128'(1));
        chk("rst_out_valid", 128'(out_valid1), 128'(0));
        chk("rst_out_data", out_data1, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit iv, ordy, fl;
        rst_n = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Single block, consumer always ready
        send_bytes(8'h00, 16, 1'b1);
        chk("blk0_t1", out_data1, 128'h0004080C_0105090D_02060A0E_03070B0F);
        chk("blk0_t0", out_data0, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        chk("blk0_valid", 128'(out_valid1), 128'(1));
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        chk("blk0_one_cycle", 128'(out_valid1), 128'(0));

        // Two blocks with consumer stalled, then a single out_ready pulse
        send_bytes(8'h00, 16, 1'b0);
        send_bytes(8'h10, 16, 1'b0);
        chk("stall_in_ready", 128'(in_ready1), 128'(0));
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0, 1'b0);
        chk("stall_hold_blk1", out_data1, 128'h0004080C_0105090D_02060A0E_03070B0F);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        chk("pend_release_blk2", out_data1, 128'h1014181C_1115191D_12161A1E_13171B1F);
        chk("pend_release_valid", 128'(out_valid1), 128'(1));
        chk("pend_release_ready", 128'(in_ready1), 128'(1));

        // Out handshake on the same edge as the 16th byte of the next block
        send_bytes(8'h20, 15, 1'b0);
        cycle(8'h2F, 1'b1, 1'b1, 1'b0);
        chk("simul_blk3", out_data1, 128'h2024282C_2125292D_22262A2E_23272B2F);
        chk("simul_valid", 128'(out_valid1), 128'(1));
        chk("simul_no_pend", 128'(in_ready1), 128'(1));
        cycle(8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-block
        send_bytes(8'h60, 7, 1'b1);
        apply_reset();
        send_bytes(8'hA0, 16, 1'b1);
        chk("after_rst_t1", out_data1, 128'hA0A4A8AC_A1A5A9AD_A2A6AAAE_A3A7ABAF);
        chk("after_rst_t0", out_data0, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);

`ifdef BLOCK_RX_FLUSH_EN
        // Flush mid-block while a block is held in the slot
        send_bytes(8'h00, 16, 1'b0);
        send_bytes(8'h50, 5, 1'b0);
        cycle(8'hEE, 1'b1, 1'b0, 1'b1);
        chk("flush_hold", out_data1, 128'h0004080C_0105090D_02060A0E_03070B0F);
        chk("flush_hold_valid", 128'(out_valid1), 128'(1));
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        send_bytes(8'hB0, 16, 1'b1);
        chk("flush_clean_blk", out_data1, 128'hB0B4B8BC_B1B5B9BD_B2B6BABE_B3B7BBBF);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic with random backpressure
        for (int c = 0; c < 800; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
`ifdef BLOCK_RX_FLUSH_EN
            fl   = ($urandom_range(0, 60) == 0);
`else
            fl   = 1'b0;
`endif
            cycle(8'($urandom), iv, ordy, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_rx_transpose.md
# block_rx_transpose

Byte-serial receiver that assembles a 128-bit AES state from a stream of 16 bytes. It is the inbound end of the state-block path. Bytes arrive in row-major order and are written directly into their column-major state positions, so the transpose is fused into deserialization. Completed blocks are held in an output slot with a valid/ready handshake, and the next block can fill while the previous one waits.

## Interface
Parameters:
- TRANSPOSE, default 1. 1: byte n goes to state index k = 4*(n%4) + n/4. 0: k = n (plain big-endian packing).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a byte this cycle.
- out_data  output  128  assembled block; state index k occupies bits [127-8k : 120-8k].
- out_valid  output  1  out_data holds a complete block.
- out_ready  input  1  consumer takes the block this cycle.
- flush  input  1  only with BLOCK_RX_FLUSH_EN; see Configuration.

## Operation
- Accept: in_valid && in_ready at an edge. The accepted byte is written to fill_buf[k(cnt)], and cnt increments mod 16.
- Placement with TRANSPOSE=1: k = {cnt[1:0], cnt[3:2]}. Row r = cnt[3:2], column c = cnt[1:0], and k = 4c + r.
- Storage: fill_buf (128 bits), out_buf (128 bits), cnt (4 bits), pend (1 bit), out_valid (1 bit).
- States (derived from cnt/pend):
  - FILL: pend=0. in_ready=1.
  - PENDING: pend=1. Full block is in fill_buf and out_buf is occupied. in_ready=0.
- Slot free condition: slot_free = !out_valid || out_ready.
- 16th byte accepted (cnt==15), slot_free: the block moves to out_buf at the same edge, with the final byte merged in. out_valid becomes 1, cnt wraps to 0, state stays FILL.
- 16th byte accepted, !slot_free: pend becomes 1 and the state enters PENDING.
- In PENDING with out_ready=1: fill_buf moves to out_buf, out_valid stays 1, pend becomes 0. in_ready returns to 1 the next cycle. There is no same-cycle byte acceptance in PENDING.
- Output handshake: out_valid && out_ready with no new block arriving clears out_valid at the edge.
- Simultaneous handshakes: out handshake plus a new block arriving on the same edge leaves out_valid=1 with out_data replaced by the new block.
- out_data stays stable while out_valid && !out_ready.
- Bytes of the next block written during FILL never disturb out_buf.
- in_valid while in_ready=0 is ignored. The producer must hold the byte.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, cnt=0, pend=0, fill_buf=0.
- Latency: when the 16th byte is accepted at edge N with the slot free, out_valid=1 from edge N. The block is visible in the cycle after N.
- Throughput: one byte per cycle sustained while the consumer keeps up, giving back-to-back blocks every 16 cycles.
- Stall cost: each PENDING episode removes at least one byte slot from in_ready.
- Reset mid-block: the partial block is discarded and the stream restarts at byte 0.
- in_ready depends only on registered state. It has no combinational path from out_ready.

## Configuration
- BLOCK_RX_FLUSH_EN defined:
  - The flush input exists. flush=1 at an edge clears cnt and pend and discards fill_buf contents.
  - out_buf and out_valid are unaffected.
  - A byte accepted on the same edge as flush is dropped.
- BLOCK_RX_FLUSH_EN undefined: there is no flush port, and only rst_n realigns the stream.

## Structure
- Shared package aes_block_pkg contains:
  - BLOCK_BYTES = 16.
  - Function place_idx(n, transpose) returning k.
  - Typedef state_t for the 128-bit state.
- One sub-module, block_slot: a 128-bit register plus valid flag. It has a load strobe and a consumer handshake, and owns out_buf and out_valid.

## Test plan
- Bytes 0x00..0x0F back-to-back, out_ready=1 -> out_data = 0x0004080C_0105090D_02060A0E_03070B0F; out_valid high for one cycle, starting the cycle after byte 15's edge.
- Same stream with TRANSPOSE=0 -> out_data = 0x00010203_04050607_08090A0B_0C0D0E0F.
- Two blocks (0x00..0x0F, 0x10..0x1F) with out_ready=0 -> in_ready drops after byte 0x1F and the first block stays stable. Raising out_ready for one cycle then shows the second block, 0x1014181C_..., and in_ready returns to 1 the next cycle.
- out_ready pulsed on the same edge that 16th byte of block 2 is accepted -> out_valid stays 1, data switches directly to block 2, pend stays 0.
- rst_n asserted after 7 bytes, then bytes 0xA0..0xAF -> output contains only 0xA0..0xAF, transposed.
- BLOCK_RX_FLUSH_EN: flush after 5 bytes, then 16 fresh bytes -> a clean block, and a held out_buf is untouched by the flush.
